toggle_event_decoder: RTL and testbench

Receive-side partner of the T flip-flop toggle encoder. The transmitter flips a level (Q) once per event. This block synchronizes that level into the local clock domain and turns each transition into one event. Events are held in a saturating pending counter and delivered one at a time over a valid/ready handshake. Sits at the consumer end of any toggle-signalled link (cross-domain event passing, slow remote strobes).

---
 rtl/toggle_event_decoder.sv | 179 +++++++++++++++++
 tb/tb_toggle_event_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
//
// Receive-side partner of a T flip-flop toggle encoder. The remote side flips a
// level once per event; this block synchronizes that level into CLK, turns each
// transition into one event, keeps a saturating backlog of undelivered events
// and hands them out one at a time over a valid/ready handshake.
//
// Parameters:
//   CNT_W        width of the pending-event counter (max backlog 2^CNT_W-1)
//   SYNC_STAGES  synchronizer depth on TOG_IN, legal range 2..4
//
// Ports:
//   CLK        in   single clock, all state changes on the rising edge
//   RESET      in   synchronous, active-high reset
//   TOG_IN     in   toggle level from the remote T flip-flop (async to CLK)
//   EVT_VALID  out  at least one undelivered event is pending
//   EVT_READY  in   consumer takes one event when high together with EVT_VALID
//   PENDING    out  current undelivered event count (saturating)
//   OVERFLOW   out  sticky, an event arrived while PENDING was saturated
//   PRIMED     out  high once the decoder is in RUN and counting events
//   EVT_TOTAL  out  (only with TOG_DEC_EVT_TOTAL_EN) 16-bit wrapping count of
//                   every detected event, including ones lost to overflow
//
// Optional feature macro: TOG_DEC_EVT_TOTAL_EN
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TOG_IN,
    output logic             EVT_VALID,
    input  logic             EVT_READY,
    output logic [CNT_W-1:0] PENDING,
    output logic             OVERFLOW,
    output logic             PRIMED
`ifdef TOG_DEC_EVT_TOTAL_EN
    ,
    output logic [15:0]      EVT_TOTAL
`endif
);

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] PEND_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ZERO  = {CNT_W{1'b0}};
    // PRIME lasts SYNC_STAGES+1 edges: counter runs 0..SYNC_STAGES, then leaves.
    localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic                   prev_q,      prev_d;
    logic                   evt_q,       evt_d;
    state_e                 state_q,     state_d;
    logic [2:0]             prime_cnt_q, prime_cnt_d;
    logic [CNT_W-1:0]       pending_q,   pending_d;
    logic                   valid_q,     valid_d;
    logic                   overflow_q,  overflow_d;
    logic                   primed_q,    primed_d;
`ifdef TOG_DEC_EVT_TOTAL_EN
    logic [15:0]            total_q,     total_d;
`endif

    logic sync_lvl_s;
    logic accept_s;

    assign sync_lvl_s = sync_q[SYNC_STAGES-1];
    // valid_q mirrors (pending_q != 0), so accept can never underflow.
    assign accept_s   = valid_q & EVT_READY;

    // Synchronizer shift, PRIME/RUN sequencing and edge detection.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], TOG_IN};
        prev_d      = sync_lvl_s;
        evt_d       = 1'b0;
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            ST_PRIME: begin
                // Only track the level here so a TOG_IN already high at reset
                // release is absorbed into prev instead of becoming an event.
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + 3'd1;
                end
            end
            ST_RUN: begin
                evt_d = sync_lvl_s ^ prev_q;
            end
            default: begin
                state_d     = ST_PRIME;
                prime_cnt_d = 3'd0;
            end
        endcase
        primed_d = (state_d == ST_RUN);
    end

    // Pending counter: saturating, increment on event, decrement on accept.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        case ({evt_q, accept_s})
            2'b10: begin
                if (pending_q == PEND_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d = pending_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            2'b01: begin
                pending_d = pending_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
                pending_d = pending_q;
            end
        endcase
        valid_d = (pending_d != PEND_ZERO);
    end

`ifdef TOG_DEC_EVT_TOTAL_EN
    // Free-running total of detected events, wraps naturally at 16 bits.
    always_comb begin
        if (evt_q) begin
            total_d = total_q + 16'd1;
        end else begin
            total_d = total_q;
        end
    end
`endif

    // State register with synchronous reset; reset wins over any handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q      <= {SYNC_STAGES{1'b0}};
            prev_q      <= 1'b0;
            evt_q       <= 1'b0;
            state_q     <= ST_PRIME;
            prime_cnt_q <= 3'd0;
            pending_q   <= PEND_ZERO;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            evt_q       <= evt_d;
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            pending_q   <= pending_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            primed_q    <= primed_d;
        end
    end

`ifdef TOG_DEC_EVT_TOTAL_EN
    // Event total register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            total_q <= 16'd0;
        end else begin
            total_q <= total_d;
        end
    end

    assign EVT_TOTAL = total_q;
`endif

    assign EVT_VALID = valid_q;
    assign PENDING   = pending_q;
    assign OVERFLOW  = overflow_q;
    assign PRIMED    = primed_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// Bench for toggle_event_decoder. Inputs change 1 ns after each rising edge and
// outputs are compared 1 ns after the edge against a reference model built from
// the block's rules: a TOG_IN change sampled at edge n is delivered as an event
// at edge n+3, counting starts once the block is primed, the backlog saturates
// at 2^CNT_W-1 and accepts happen whenever EVT_READY meets a nonzero backlog.
// -----------------------------------------------------------------------------
module tb_toggle_event_decoder;

    localparam int CNT_W    = 4;
    localparam int PEND_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             TOG_IN = 1'b0;
    logic             EVT_READY = 1'b0;
    logic             EVT_VALID;
    logic [CNT_W-1:0] PENDING;
    logic             OVERFLOW;
    logic             PRIMED;
`ifdef TOG_DEC_EVT_TOTAL_EN
    logic [15:0]      EVT_TOTAL;
`endif

    toggle_event_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TOG_IN    (TOG_IN),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .PENDING   (PENDING),
        .OVERFLOW  (OVERFLOW),
        .PRIMED    (PRIMED)
`ifdef TOG_DEC_EVT_TOTAL_EN
        ,
        .EVT_TOTAL (EVT_TOTAL)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_pend   = 0;
    bit m_ovf    = 1'b0;
    int m_edges  = 0;     // edges since the last reset edge
    int m_total  = 0;
    bit hist[$];          // TOG_IN as sampled on the most recent edges
    bit tog_lvl  = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge.
    task automatic model_edge(input bit rst, input bit tog, input bit rdy);
        bit evt;
        bit acc;
        if (rst) begin
            m_pend  = 0;
            m_ovf   = 1'b0;
            m_edges = 0;
            m_total = 0;
            hist.delete();
        end else begin
            m_edges++;
            hist.push_back(tog);
            if (hist.size() > 5) void'(hist.pop_front());
            // change between edges m-4 and m-3 lands now; needs m-3 >= 2
            evt = (m_edges >= 5) && (hist[hist.size()-4] != hist[hist.size()-5]);
            acc = rdy && (m_pend != 0);
            if (evt) m_total = (m_total + 1) % 65536;
            if (evt && !acc) begin
                if (m_pend == PEND_MAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (acc && !evt) begin
                m_pend--;
            end
        end
    endtask

    // Drive one cycle of inputs, take the edge, compare everything.
    task automatic cyc(input bit rst, input bit tog, input bit rdy);
        RESET     = rst;
        TOG_IN    = tog;
        EVT_READY = rdy;
        @(posedge CLK);
        #1;
        model_edge(rst, tog, rdy);
        check_eq("pending",   int'(PENDING),   m_pend);
        check_eq("evt_valid", int'(EVT_VALID), (m_pend != 0) ? 1 : 0);
        check_eq("overflow",  int'(OVERFLOW),  int'(m_ovf));
        check_eq("primed",    int'(PRIMED),    (m_edges >= 3) ? 1 : 0);
`ifdef TOG_DEC_EVT_TOTAL_EN
        check_eq("evt_total", int'(EVT_TOTAL), m_total);
`endif
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, tog_lvl, rdy);
    endtask

    task automatic flip(input bit rdy);
        tog_lvl = ~tog_lvl;
        cyc(1'b0, tog_lvl, rdy);
    endtask

    int pct_tab[4] = '{0, 25, 50, 90};

    initial begin
        // 1: reset with TOG_IN already high, no spurious event
        tog_lvl = 1'b1;
        cyc(1'b1, tog_lvl, 1'b0);
        cyc(1'b1, tog_lvl, 1'b0);
        idle(10, 1'b0);
        check_eq("s1_primed", int'(PRIMED), 1);
        check_eq("s1_pending", int'(PENDING), 0);

        // 2: two events with 3-edge latency, consumer stalled
        flip(1'b0);
        idle(2, 1'b0);
        check_eq("s2_before_latency", int'(PENDING), 0);
        idle(1, 1'b0);
        check_eq("s2_first_evt", int'(PENDING), 1);
        flip(1'b0);
        idle(3, 1'b0);
        check_eq("s2_second_evt", int'(PENDING), 2);

        // 3: drain two with READY held
        idle(4, 1'b1);
        check_eq("s3_drained", int'(PENDING), 0);
        check_eq("s3_valid_low", int'(EVT_VALID), 0);

        // 4: saturation and sticky overflow
        cyc(1'b1, tog_lvl, 1'b0);
        idle(4, 1'b0);
        for (int i = 0; i < 17; i++) begin
            flip(1'b0);
            idle(3, 1'b0);
        end
        idle(4, 1'b0);
        check_eq("s4_saturated", int'(PENDING), PEND_MAX);
        check_eq("s4_overflow", int'(OVERFLOW), 1);
`ifdef TOG_DEC_EVT_TOTAL_EN
        check_eq("s4_total", int'(EVT_TOTAL), 17);
`endif
        idle(15, 1'b1);
        check_eq("s4_drained", int'(PENDING), 0);
        check_eq("s4_overflow_sticky", int'(OVERFLOW), 1);
        idle(2, 1'b1);

        // 5: event and accept on the same edge leave the count unchanged
        for (int i = 0; i < 5; i++) begin
            flip(1'b0);
            idle(1, 1'b0);
        end
        idle(4, 1'b0);
        check_eq("s5_setup", int'(PENDING), 5);
        flip(1'b0);
        idle(2, 1'b0);
        cyc(1'b0, tog_lvl, 1'b1);
        check_eq("s5_coincident", int'(PENDING), 5);
        cyc(1'b0, tog_lvl, 1'b1);
        check_eq("s5_accept_only", int'(PENDING), 4);
        for (int i = 0; i < 3; i++) begin
            flip(1'b0);
            idle(1, 1'b0);
        end
        idle(4, 1'b0);
        check_eq("s6_setup", int'(PENDING), 7);

        // 6: reset during an active handshake
        cyc(1'b1, tog_lvl, 1'b1);
        check_eq("s6_pending", int'(PENDING), 0);
        check_eq("s6_overflow", int'(OVERFLOW), 0);
        check_eq("s6_primed", int'(PRIMED), 0);
        idle(3, 1'b1);
        check_eq("s6_reprimed", int'(PRIMED), 1);

        // Random traffic with varying consumer pressure and rare resets
        for (int seg = 0; seg < 8; seg++) begin
            int pct;
            pct = pct_tab[seg % 4];
            for (int i = 0; i < 60; i++) begin
                bit rst;
                bit rdy;
                if ($urandom_range(0, 99) < 35) tog_lvl = ~tog_lvl;
                rdy = ($urandom_range(0, 99) < pct);
                rst = ($urandom_range(0, 299) == 0);
                cyc(rst, tog_lvl, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
